test_result_checker: RTL and testbench

//  Scoreboard on the consuming side of the test_top-style add/sub datapath after the flop-insertion flow.
//  - Captures each operand set (b, c) when offered.
//  - Recomputes expected result = (c + b) + (b - c), mod 2^W.
//  - Matches the DUT result stream in order, tolerating any inserted latency.
//  - Reports pass/fail counts, sticky error and first-failure capture.

---
 rtl/test_chk_pkg.sv | 33 +++
 rtl/test_chk_fifo.sv | 65 ++++++
 rtl/test_result_checker.sv | 155 +++++++++++++++
 tb/tb_test_result_checker.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/test_chk_pkg.sv
// Shared definitions for the add/sub result checker: FSM state codes and the
// expected-value rule applied to every captured operand set.
package test_chk_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FAIL = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_RUN  = RUN,
        ST_FAIL = FAIL
    } chk_state_e;

    // Widest result the helper can model; instantiations must keep W <= MAX_W.
    localparam int MAX_W = 32;

    // Mirrors the datapath literally: both intermediate ops truncate to w bits.
    function automatic logic [MAX_W-1:0] calc_exp(
        input logic [MAX_W-1:0] b,
        input logic [MAX_W-1:0] c,
        input int               w
    );
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] sum;
        logic [MAX_W-1:0] diff;
        mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
        sum  = (c + b) & mask;
        diff = (b - c) & mask;
        return (sum + diff) & mask;
    endfunction

endpackage

// File: rtl/test_chk_fifo.sv
// Expectation queue: synchronous FIFO with a show-ahead head, flush and
// occupancy count. A write becomes visible at the head one cycle later.
module test_chk_fifo #(
    parameter int W  = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam int DEPTH = 2 ** AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // A full queue still accepts a write when the head leaves in the same cycle.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/test_result_checker.sv
// In-order scoreboard for the add/sub datapath: queues expected results at
// operand time and checks the DUT result stream against them at any latency.
module test_result_checker
    import test_chk_pkg::*;
#(
    parameter int W     = 8,
    parameter int AW    = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             chk_en,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [W-1:0]     in_b,
    input  logic [W-1:0]     in_c,
    input  logic             res_valid,
    input  logic [W-1:0]     res,
    output logic             err,
    output logic             ovf,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [W-1:0]     fail_exp,
    output logic [W-1:0]     fail_got,
    output logic [1:0]       state
);

    chk_state_e state_q;
    chk_state_e state_d;

    logic         active;
    logic         push_req;
    logic         pop_req;
    logic         pop_ok;
    logic         underflow;
    logic         matched;
    logic         mismatch;
    logic         failure;
    logic         ovf_evt;
    logic         flush;
    logic [W-1:0] exp_val;
    logic [W-1:0] q_head;
    logic         q_full;
    logic         q_empty;
    logic [AW:0]  q_count;

    assign exp_val = W'(calc_exp(MAX_W'(in_b), MAX_W'(in_c), W));

    // clr wins over everything, so it masks the cycle's push and pop outright.
    assign active    = (state_q != ST_IDLE);
    assign push_req  = in_valid && active && !clr;
    assign pop_req   = res_valid && active && !clr;
    assign pop_ok    = pop_req && !q_empty;
    assign underflow = pop_req && q_empty;
    assign matched   = pop_ok && (res == q_head);
    assign mismatch  = pop_ok && (res != q_head);
    assign failure   = underflow || mismatch;
    assign ovf_evt   = push_req && q_full && !pop_ok;
    assign flush     = clr || (active && !chk_en);

    test_chk_fifo #(
        .W  (W),
        .AW (AW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push_req),
        .pop   (pop_req),
        .din   (exp_val),
        .head  (q_head),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    assert property (@(posedge clk) disable iff (!rst_n)
        q_full == (q_count == (AW+1)'(2 ** AW)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Dropping chk_en outranks a failure seen in the same cycle.
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = chk_en ? ST_RUN : ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (chk_en) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!chk_en) begin
                        state_d = ST_IDLE;
                    end else if (failure) begin
                        state_d = ST_FAIL;
                    end
                end
                ST_FAIL: begin
                    if (!chk_en) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
            err      <= 1'b0;
            ovf      <= 1'b0;
            fail_exp <= '0;
            fail_got <= '0;
        end else if (clr) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
            err      <= 1'b0;
            ovf      <= 1'b0;
            fail_exp <= '0;
            fail_got <= '0;
        end else begin
            if (matched && (pass_cnt != '1)) begin
                pass_cnt <= pass_cnt + CNT_W'(1);
            end
            if (failure && (fail_cnt != '1)) begin
                fail_cnt <= fail_cnt + CNT_W'(1);
            end
            if (failure || ovf_evt) begin
                err <= 1'b1;
            end
            if (ovf_evt) begin
                ovf <= 1'b1;
            end
            // Only the first failure is kept; an underflow has no expectation.
            if (failure && (state_q == ST_RUN)) begin
                fail_exp <= underflow ? '0 : q_head;
                fail_got <= res;
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_test_result_checker.sv
// Directed bench for test_result_checker: a queue-based reference model checked
// every cycle, plus hand-computed spot checks at the interesting points.
module tb_test_result_checker;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       chk_en = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_b = '0;
    logic [7:0] in_c = '0;
    logic       res_valid = 1'b0;
    logic [7:0] res = '0;

    logic        err_a, ovf_a;
    logic [15:0] pass_a, fail_a;
    logic [7:0]  fexp_a, fgot_a;
    logic [1:0]  state_a;

    logic        err_s, ovf_s;
    logic [3:0]  pass_s, fail_s;
    logic [7:0]  fexp_s, fgot_s;
    logic [1:0]  state_s;

    int total = 0;
    int bad = 0;

    // Reference model state
    int m_q[$];
    int m_state;
    int m_pass;
    int m_fail;
    int m_fexp;
    int m_fgot;
    bit m_err;
    bit m_ovf;

    always #5 clk = ~clk;

    test_result_checker #(.W(8), .AW(3), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .clr(clr),
        .in_valid(in_valid), .in_b(in_b), .in_c(in_c),
        .res_valid(res_valid), .res(res),
        .err(err_a), .ovf(ovf_a), .pass_cnt(pass_a), .fail_cnt(fail_a),
        .fail_exp(fexp_a), .fail_got(fgot_a), .state(state_a)
    );

    test_result_checker #(.W(8), .AW(3), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .clr(clr),
        .in_valid(in_valid), .in_b(in_b), .in_c(in_c),
        .res_valid(res_valid), .res(res),
        .err(err_s), .ovf(ovf_s), .pass_cnt(pass_s), .fail_cnt(fail_s),
        .fail_exp(fexp_s), .fail_got(fgot_s), .state(state_s)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int satv(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // The (c+b)+(b-c) datapath collapses to 2*b modulo 256.
    function automatic int expect_of(input logic [7:0] b);
        return (2 * int'(b)) % 256;
    endfunction

    task automatic modelStep();
        bit active;
        bit failure;
        int cap;
        int e;
        if (clr) begin
            m_q.delete();
            m_pass = 0; m_fail = 0; m_err = 0; m_ovf = 0; m_fexp = 0; m_fgot = 0;
            m_state = chk_en ? 1 : 0;
            return;
        end
        active  = (m_state != 0);
        failure = 0;
        cap     = 0;
        if (active && res_valid) begin
            if (m_q.size() == 0) begin
                failure = 1;
            end else begin
                e = m_q.pop_front();
                if (e == int'(res)) m_pass++;
                else begin
                    failure = 1;
                    cap = e;
                end
            end
            if (failure) begin
                m_fail++;
                m_err = 1;
                if (m_state == 1) begin
                    m_fexp = cap;
                    m_fgot = int'(res);
                end
            end
        end
        if (active && in_valid) begin
            if (m_q.size() < DEPTH) m_q.push_back(expect_of(in_b));
            else begin
                m_ovf = 1;
                m_err = 1;
            end
        end
        if (active && !chk_en) m_q.delete();
        if (m_state == 0 && chk_en) m_state = 1;
        else if (m_state != 0 && !chk_en) m_state = 0;
        else if (m_state == 1 && failure) m_state = 2;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_state = 0; m_pass = 0; m_fail = 0; m_fexp = 0; m_fgot = 0;
            m_err = 0; m_ovf = 0;
        end else begin
            modelStep();
        end
    end

    always @(negedge clk) begin
        checkOutput("err", 32'(err_a), 32'(m_err));
        checkOutput("ovf", 32'(ovf_a), 32'(m_ovf));
        checkOutput("pass_cnt", 32'(pass_a), satv(m_pass, 65535));
        checkOutput("fail_cnt", 32'(fail_a), satv(m_fail, 65535));
        checkOutput("fail_exp", 32'(fexp_a), m_fexp);
        checkOutput("fail_got", 32'(fgot_a), m_fgot);
        checkOutput("state", 32'(state_a), m_state);
        checkOutput("sat.err", 32'(err_s), 32'(m_err));
        checkOutput("sat.ovf", 32'(ovf_s), 32'(m_ovf));
        checkOutput("sat.pass_cnt", 32'(pass_s), satv(m_pass, 15));
        checkOutput("sat.fail_cnt", 32'(fail_s), satv(m_fail, 15));
        checkOutput("sat.fail_exp", 32'(fexp_s), m_fexp);
        checkOutput("sat.fail_got", 32'(fgot_s), m_fgot);
        checkOutput("sat.state", 32'(state_s), m_state);
    end

    // Drives one cycle of inputs just after a rising edge and returns after the next.
    task automatic applyStimulus(input logic en, input logic cl, input logic iv,
                                 input logic [7:0] b, input logic [7:0] c,
                                 input logic rv, input logic [7:0] r);
        chk_en    = en;
        clr       = cl;
        in_valid  = iv;
        in_b      = b;
        in_c      = c;
        res_valid = rv;
        res       = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        checkOutput("t1.reset_state", 32'(state_a), 0);
        checkOutput("t1.reset_pass", 32'(pass_a), 0);
        #20 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // T1: activity while disabled must not count
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 8'(i + 1), 8'd2, 1, 8'd4);
        checkOutput("t1.idle_pass", 32'(pass_a), 0);
        checkOutput("t1.idle_fail", 32'(fail_a), 0);
        checkOutput("t1.idle_state", 32'(state_a), 0);

        // T2: two matches at latency 2
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 8'd3, 8'd5, 0, 0);
        applyStimulus(1, 0, 1, 8'd200, 8'd1, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 8'd6);
        applyStimulus(1, 0, 0, 0, 0, 1, 8'd144);
        checkOutput("t2.pass", 32'(pass_a), 2);
        checkOutput("t2.err", 32'(err_a), 0);
        checkOutput("t2.state", 32'(state_a), 1);

        // T3: first mismatch captured, second counted only
        applyStimulus(1, 0, 1, 8'd3, 8'd5, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 8'd7);
        applyStimulus(1, 0, 1, 8'd1, 8'd0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 8'd9);
        checkOutput("t3.fail", 32'(fail_a), 2);
        checkOutput("t3.fail_exp", 32'(fexp_a), 6);
        checkOutput("t3.fail_got", 32'(fgot_a), 7);
        checkOutput("t3.state", 32'(state_a), 2);

        // T1: asynchronous reset in the middle of a cycle
        applyStimulus(1, 0, 1, 8'd4, 8'd4, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t1.mid_err", 32'(err_a), 0);
        checkOutput("t1.mid_fail", 32'(fail_a), 0);
        checkOutput("t1.mid_exp", 32'(fexp_a), 0);
        checkOutput("t1.mid_got", 32'(fgot_a), 0);
        checkOutput("t1.mid_state", 32'(state_a), 0);
        chk_en = 0; in_valid = 0; res_valid = 0;
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // T4: overflow on the ninth push, underflow on the ninth result
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) applyStimulus(1, 0, 1, 8'(10 + i), 8'(i), 0, 0);
        checkOutput("t4.ovf", 32'(ovf_a), 1);
        checkOutput("t4.fail_after_ovf", 32'(fail_a), 0);
        checkOutput("t4.state_after_ovf", 32'(state_a), 1);
        for (int i = 0; i < 9; i++)
            applyStimulus(1, 0, 0, 0, 0, 1, (i < 8) ? 8'(2 * (10 + i)) : 8'h55);
        checkOutput("t4.pass", 32'(pass_a), 8);
        checkOutput("t4.underflow", 32'(fail_a), 1);
        checkOutput("t4.uf_exp", 32'(fexp_a), 0);
        checkOutput("t4.uf_got", 32'(fgot_a), 32'h55);

        // T4: push and pop together on a full queue
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) applyStimulus(1, 0, 1, 8'(40 + i), 8'd7, 0, 0);
        applyStimulus(1, 0, 1, 8'd48, 8'd3, 1, 8'd80);
        checkOutput("t4.full_pushpop_ovf", 32'(ovf_a), 0);
        checkOutput("t4.full_pushpop_pass", 32'(pass_a), 1);

        // T5: clr with three entries still queued
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 0, 1, 8'(2 * (41 + i)));
        checkOutput("t5.pre_pass", 32'(pass_a), 6);
        applyStimulus(1, 1, 1, 8'd9, 8'd9, 1, 8'd92);
        checkOutput("t5.pass", 32'(pass_a), 0);
        checkOutput("t5.err", 32'(err_a), 0);
        checkOutput("t5.state", 32'(state_a), 1);
        applyStimulus(1, 0, 0, 0, 0, 1, 8'd92);
        checkOutput("t5.stale_fail", 32'(fail_a), 1);
        checkOutput("t5.stale_state", 32'(state_a), 2);

        // T6: twenty matches saturate a 4-bit counter
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i <= 20; i++)
            applyStimulus(1, 0, (i < 20), 8'(i + 1), 8'(3 * i), (i > 0), 8'(2 * i));
        checkOutput("t6.pass16", 32'(pass_a), 20);
        checkOutput("t6.pass4", 32'(pass_s), 15);
        checkOutput("t6.fail", 32'(fail_a), 0);

        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
